wb_write_arbiter: RTL and testbench

//  Writer side of the 1-write-port register file for the dual-issue pipe.
//  - Takes up to two retiring writebacks per cycle (lane0 older, lane1 younger).
//  - Queues them in program order.
//  - Drains one per cycle into write/wr/wd of the register file.
//  - Backpressures both lanes through stall when it cannot take a pair.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_queue.sv | 66 ++++++
 rtl/wb_write_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register/data widths and the queued entry format.
package wb_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Two-in/one-out circular buffer of writeback entries; exposes its storage for bypass search.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  push_n_i,
    input  wb_entry_t                   push0_i,
    input  wb_entry_t                   push1_i,
    input  logic                        pop_i,
    output wb_entry_t                   head_o,
    output logic [CntW-1:0]             count_o,
    output logic [CntW-1:0]             count_next_o,
    output logic [PtrW-1:0]             rd_ptr_o,
    output wb_entry_t [DEPTH-1:0]       entries_o
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_pop;

    always_comb begin
        mem_d     = mem_q;
        do_pop    = pop_i && (count_q != '0);
        wr_ptr_p1 = wr_ptr_q + PtrW'(1);

        // push0 always lands at the tail; push1 only exists alongside push0
        if (push_n_i != 2'd0) begin
            mem_d[wr_ptr_q] = push0_i;
        end
        if (push_n_i == 2'd2) begin
            mem_d[wr_ptr_p1] = push1_i;
        end

        wr_ptr_d = wr_ptr_q + PtrW'(push_n_i);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        count_d  = count_q + CntW'(push_n_i) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign rd_ptr_o     = rd_ptr_q;
    assign entries_o    = mem_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges two retiring writeback lanes into the single register-file write port, in program order.
// Bypass search over pending writes is built only when WB_BYPASS_EN is defined.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb0_valid_i,
    input  logic [REG_W-1:0]  wb0_reg_i,
    input  logic [DATA_W-1:0] wb0_data_i,
    input  logic              wb1_valid_i,
    input  logic [REG_W-1:0]  wb1_reg_i,
    input  logic [DATA_W-1:0] wb1_data_i,
    output logic              stall_o,
    output logic              rf_write_o,
    output logic [REG_W-1:0]  rf_wr_o,
    output logic [DATA_W-1:0] rf_wd_o,
    input  logic [REG_W-1:0]  q0_reg_i,
    input  logic [REG_W-1:0]  q1_reg_i,
    output logic              q0_hit_o,
    output logic [DATA_W-1:0] q0_data_o,
    output logic              q1_hit_o,
    output logic [DATA_W-1:0] q1_data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                  acc0, acc1, en0;
    logic [1:0]            push_n;
    wb_entry_t             lane0, lane1, slot0, slot1, head;
    logic [CntW-1:0]       count, count_next;
    logic [PtrW-1:0]       rd_ptr;
    wb_entry_t [DEPTH-1:0] entries;
    logic                  stall_q, stall_d;

    always_comb begin
        acc0 = wb0_valid_i && !stall_q && (wb0_reg_i != '0);
        acc1 = wb1_valid_i && !stall_q && (wb1_reg_i != '0);
        // Same destination in one cycle: the younger lane's value is the only one that matters
        en0  = acc0 && !(acc1 && (wb0_reg_i == wb1_reg_i));

        lane0.rd   = wb0_reg_i;
        lane0.data = wb0_data_i;
        lane1.rd   = wb1_reg_i;
        lane1.data = wb1_data_i;

        push_n = {1'b0, en0} + {1'b0, acc1};
        slot0  = en0 ? lane0 : lane1;
        slot1  = lane1;
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_n_i     (push_n),
        .push0_i      (slot0),
        .push1_i      (slot1),
        .pop_i        (rf_write_o),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next),
        .rd_ptr_o     (rd_ptr),
        .entries_o    (entries)
    );

    // Registered so that whenever stall is low a full pair is guaranteed to fit
    assign stall_d = (32'(count_next) > (DEPTH - 32'd2));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_o    = stall_q;
    assign rf_write_o = (count != '0);
    assign rf_wr_o    = head.rd;
    assign rf_wd_o    = head.data;

`ifdef WB_BYPASS_EN
    logic [PtrW-1:0] bp_idx;

    always_comb begin
        q0_hit_o  = 1'b0;
        q0_data_o = '0;
        q1_hit_o  = 1'b0;
        q1_data_o = '0;
        bp_idx    = rd_ptr;
        // Walk oldest to youngest so the last match (youngest) wins
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bp_idx = rd_ptr + PtrW'(i);
            if (i < 32'(count)) begin
                if ((q0_reg_i != '0) && (entries[bp_idx].rd == q0_reg_i)) begin
                    q0_hit_o  = 1'b1;
                    q0_data_o = entries[bp_idx].data;
                end
                if ((q1_reg_i != '0) && (entries[bp_idx].rd == q1_reg_i)) begin
                    q1_hit_o  = 1'b1;
                    q1_data_o = entries[bp_idx].data;
                end
            end
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{q0_reg_i, q1_reg_i, rd_ptr, entries};
    assign q0_hit_o      = 1'b0;
    assign q0_data_o     = '0;
    assign q1_hit_o      = 1'b0;
    assign q1_data_o     = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_wb_write_arbiter;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_reg, wb1_reg;
    logic [31:0] wb0_data, wb1_data;
    logic        stall, rf_write;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [4:0]  q0_reg, q1_reg;
    logic        q0_hit, q1_hit;
    logic [31:0] q0_data, q1_data;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb0_valid_i (wb0_valid),
        .wb0_reg_i   (wb0_reg),
        .wb0_data_i  (wb0_data),
        .wb1_valid_i (wb1_valid),
        .wb1_reg_i   (wb1_reg),
        .wb1_data_i  (wb1_data),
        .stall_o     (stall),
        .rf_write_o  (rf_write),
        .rf_wr_o     (rf_wr),
        .rf_wd_o     (rf_wd),
        .q0_reg_i    (q0_reg),
        .q1_reg_i    (q1_reg),
        .q0_hit_o    (q0_hit),
        .q0_data_o   (q0_data),
        .q1_hit_o    (q1_hit),
        .q1_data_o   (q1_data)
    );

    task automatic idle_lanes();
        wb0_valid = 1'b0; wb0_reg = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_reg = '0; wb1_data = '0;
    endtask

    task automatic set_lanes(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
        wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_lanes();
        q0_reg = '0;
        q1_reg = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        #1;
    endtask

    // Reference: lanes sampled at the edge, head retires, survivors appended in program order
    task automatic model_edge();
        bit   st, a0, a1;
        ent_t e;
        st = (mq.size() > int'(DEPTH) - 2);
        a0 = wb0_valid && !st && (wb0_reg != 5'd0);
        a1 = wb1_valid && !st && (wb1_reg != 5'd0);
        if (mq.size() > 0) void'(mq.pop_front());
        if (a0 && !(a1 && (wb0_reg == wb1_reg))) begin
            e.rd = wb0_reg; e.data = wb0_data; mq.push_back(e);
        end
        if (a1) begin
            e.rd = wb1_reg; e.data = wb1_data; mq.push_back(e);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] q, output logic [31:0] d);
        d = '0;
        if (q == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == q) begin
                d = mq[i].data;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        bit exp_hit;
        do_reset();
        n_cmp++;
        if (rf_write !== 1'b0 || stall !== 1'b0 || rf_wr !== 5'd0 || rf_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle: w=%b st=%b wr=%0d wd=%h, want all 0",
                     rf_write, stall, rf_wr, rf_wd);
        end
        set_lanes(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        tick();
        set_lanes(1'b1, 5'd3, 32'h300, 1'b1, 5'd4, 32'h400);
        tick();
        idle_lanes();
        q0_reg = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        n_cmp++;
        if (stall !== 1'b1 || rf_write !== 1'b1 || rf_wr !== 5'd2 || q0_hit !== exp_hit) begin
            n_fail++;
            $display("FAIL reset_preload: st=%b w=%b wr=%0d hit=%b, want st=1 w=1 wr=2 hit=%b",
                     stall, rf_write, rf_wr, q0_hit, exp_hit);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rf_write !== 1'b0 || stall !== 1'b0 || q0_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: w=%b st=%b hit=%b, want 0 0 0", rf_write, stall, q0_hit);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (rf_write !== 1'b0 || stall !== 1'b0 || q0_hit !== 1'b0 ||
            rf_wr !== 5'd0 || rf_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_after: w=%b st=%b hit=%b wr=%0d wd=%h, want all 0",
                     rf_write, stall, q0_hit, rf_wr, rf_wd);
        end
        q0_reg = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_lanes(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        tick();
        idle_lanes();
        n_cmp++;
        if (rf_write !== 1'b1 || rf_wr !== 5'd5 || rf_wd !== 32'h11) begin
            n_fail++;
            $display("FAIL single_present: w=%b wr=%0d wd=%h, want 1 5 11", rf_write, rf_wr, rf_wd);
        end
        tick();
        n_cmp++;
        if (rf_write !== 1'b0 || rf_wr !== 5'd0 || rf_wd !== 32'd0) begin
            n_fail++;
            $display("FAIL single_empty: w=%b wr=%0d wd=%h, want 0 0 0", rf_write, rf_wr, rf_wd);
        end
    endtask

    task automatic test_pair();
        do_reset();
        set_lanes(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        tick();
        idle_lanes();
        n_cmp++;
        if (rf_write !== 1'b1 || rf_wr !== 5'd3 || rf_wd !== 32'hA) begin
            n_fail++;
            $display("FAIL pair_first: w=%b wr=%0d wd=%h, want 1 3 a", rf_write, rf_wr, rf_wd);
        end
        tick();
        n_cmp++;
        if (rf_write !== 1'b1 || rf_wr !== 5'd4 || rf_wd !== 32'hB) begin
            n_fail++;
            $display("FAIL pair_second: w=%b wr=%0d wd=%h, want 1 4 b", rf_write, rf_wr, rf_wd);
        end
        tick();
        n_cmp++;
        if (rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_drained: w=%b, want 0", rf_write);
        end
    endtask

    task automatic test_coalesce_zero();
        do_reset();
        set_lanes(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        tick();
        idle_lanes();
        n_cmp++;
        if (rf_write !== 1'b1 || rf_wr !== 5'd7 || rf_wd !== 32'd2) begin
            n_fail++;
            $display("FAIL coalesce_value: w=%b wr=%0d wd=%h, want 1 7 2", rf_write, rf_wr, rf_wd);
        end
        tick();
        n_cmp++;
        if (rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL coalesce_single: w=%b, want 0 (only one write)", rf_write);
        end
        set_lanes(1'b1, 5'd0, 32'd9, 1'b0, 5'd0, 32'd0);
        tick();
        idle_lanes();
        n_cmp++;
        if (rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dropped: w=%b wr=%0d, want no write", rf_write, rf_wr);
        end
    endtask

    task automatic test_back_to_back();
        ent_t exp_q[$];
        ent_t got_q[$];
        ent_t e;
        int   issued = 0;
        bit   st;
        do_reset();
        for (int c = 0; c < 40 && issued < 6; c++) begin
            set_lanes(1'b1, 5'(2 * issued + 1), 32'hB000 + 32'(2 * issued),
                      1'b1, 5'(2 * issued + 2), 32'hB001 + 32'(2 * issued));
            st = stall;
            tick();
            if (!st) begin
                e.rd = wb0_reg; e.data = wb0_data; exp_q.push_back(e);
                e.rd = wb1_reg; e.data = wb1_data; exp_q.push_back(e);
                issued++;
                if (issued == 2) begin
                    n_cmp++;
                    if (stall !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_stall: stall=%b after 2nd pair, want 1", stall);
                    end
                end
            end
            if (rf_write) begin
                e.rd = rf_wr; e.data = rf_wd; got_q.push_back(e);
            end
        end
        idle_lanes();
        for (int c = 0; c < 20 && rf_write; c++) begin
            tick();
            if (rf_write) begin
                e.rd = rf_wr; e.data = rf_wd; got_q.push_back(e);
            end
        end
        n_cmp++;
        if (issued != 6 || got_q.size() != exp_q.size() || rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: issued=%0d got=%0d w=%b, want issued=6 got=%0d w=0",
                     issued, got_q.size(), rf_write, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].rd !== exp_q[i].rd || got_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got r%0d=%h, want r%0d=%h", i,
                         got_q[i].rd, got_q[i].data, exp_q[i].rd, exp_q[i].data);
            end
        end
    endtask

    task automatic test_bypass();
        bit          h;
        logic [31:0] d;
        do_reset();
        set_lanes(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h1);
        tick();
        set_lanes(1'b1, 5'd11, 32'hB, 1'b1, 5'd9, 32'h2);
        tick();
        idle_lanes();
        for (int k = 0; k < 3; k++) begin
            q0_reg = 5'd9;
            q1_reg = (k == 0) ? 5'd11 : ((k == 1) ? 5'd8 : 5'd0);
            #1;
`ifdef WB_BYPASS_EN
            h = (k == 0);
            d = (k == 0) ? 32'hB : 32'h0;
            n_cmp++;
            if (q0_hit !== 1'b1 || q0_data !== 32'h2) begin
                n_fail++;
                $display("FAIL bypass_q0[%0d]: hit=%b data=%h, want 1 2", k, q0_hit, q0_data);
            end
`else
            h = 1'b0;
            d = 32'h0;
            n_cmp++;
            if (q0_hit !== 1'b0 || q0_data !== 32'h0) begin
                n_fail++;
                $display("FAIL bypass_q0_off[%0d]: hit=%b data=%h, want 0 0", k, q0_hit, q0_data);
            end
`endif
            n_cmp++;
            if (q1_hit !== h || q1_data !== d) begin
                n_fail++;
                $display("FAIL bypass_q1[%0d]: hit=%b data=%h, want %b %h",
                         k, q1_hit, q1_data, h, d);
            end
        end
        q0_reg = '0;
        q1_reg = '0;
    endtask

    task automatic test_random();
        bit          ew, est, eh0, eh1;
        logic [4:0]  ewr;
        logic [31:0] ewd, ed0, ed1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst = 1'b1;
                #1;
                mq.delete();
                n_cmp++;
                if (rf_write !== 1'b0 || stall !== 1'b0 || q0_hit !== 1'b0 || q1_hit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_reset: w=%b st=%b h0=%b h1=%b, want 0",
                             rf_write, stall, q0_hit, q1_hit);
                end
                rst = 1'b0;
            end
            set_lanes(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
            q0_reg = 5'($urandom_range(0, 7));
            q1_reg = 5'($urandom_range(0, 7));
            model_edge();
            tick();
            ew  = (mq.size() != 0);
            ewr = ew ? mq[0].rd : 5'd0;
            ewd = ew ? mq[0].data : 32'd0;
            est = (mq.size() > int'(DEPTH) - 2);
`ifdef WB_BYPASS_EN
            eh0 = model_hit(q0_reg, ed0);
            eh1 = model_hit(q1_reg, ed1);
`else
            eh0 = 1'b0; ed0 = '0;
            eh1 = 1'b0; ed1 = '0;
`endif
            n_cmp++;
            if (mq.size() > int'(DEPTH)) begin
                n_fail++;
                $display("FAIL rand_overflow cyc %0d: %0d entries, want <= %0d",
                         i, mq.size(), DEPTH);
            end
            n_cmp++;
            if (rf_write !== ew || rf_wr !== ewr || rf_wd !== ewd || stall !== est) begin
                n_fail++;
                $display("FAIL rand_head cyc %0d: w=%b wr=%0d wd=%h st=%b, want %b %0d %h %b",
                         i, rf_write, rf_wr, rf_wd, stall, ew, ewr, ewd, est);
            end
            n_cmp++;
            if (q0_hit !== eh0 || q0_data !== ed0 || q1_hit !== eh1 || q1_data !== ed1) begin
                n_fail++;
                $display("FAIL rand_bypass cyc %0d: q0=%b/%h q1=%b/%h, want %b/%h %b/%h",
                         i, q0_hit, q0_data, q1_hit, q1_data, eh0, ed0, eh1, ed1);
            end
        end
        idle_lanes();
    endtask

    initial begin
        rst = 1'b1;
        idle_lanes();
        q0_reg = '0;
        q1_reg = '0;
        test_reset();
        test_single();
        test_pair();
        test_coalesce_zero();
        test_back_to_back();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
